// File: rtl/mem_access_ctrl.sv
// Memory access controller: sole driver of the 16-bit word memory pins.
// Serves single-word writes and 1-4 beat incrementing read bursts with a backpressured response channel.
module mem_access_ctrl #(
    parameter int address_size = 16,
    parameter int data_size    = 16,
    parameter int burst_bits   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [address_size-1:0] req_addr,
    input  logic [data_size-1:0]    req_wdata,
    input  logic [burst_bits-1:0]   req_len,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_size-1:0]    rsp_rdata,
    output logic                    rsp_last,
    output logic                    busy,
    output logic [address_size-1:0] mem_address,
    output logic                    mem_read_write,
    output logic                    mem_enable,
    output logic                    mem_output_en,
    output logic [data_size-1:0]    mem_data_out,
    input  logic [data_size-1:0]    mem_data_in
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        RD_ISSUE   = 3'd2,
        RD_CAPTURE = 3'd3,
        RESP       = 3'd4
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [address_size-1:0]   addr_q;
    logic [data_size-1:0]      wdata_q;
    logic [burst_bits-1:0]     count_q;
    logic                      accept;
    logic                      rsp_hs;

    // Unsigned increment that wraps at the top of the address space.
    function automatic logic [address_size-1:0] next_addr(input logic [address_size-1:0] a);
        return a + {{(address_size-1){1'b0}}, 1'b1};
    endfunction

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = (state == RESP) && rsp_valid && rsp_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_write ? WRITE : RD_ISSUE;
                end
            end
            WRITE:      state_nxt = IDLE;
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = RESP;
            RESP: begin
                if (rsp_hs) begin
                    state_nxt = rsp_last ? IDLE : RD_ISSUE;
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Memory pins: the read controls stay up through capture so the output register keeps driving.
    always_comb begin
        mem_address    = addr_q;
        mem_read_write = 1'b0;
        mem_enable     = 1'b0;
        mem_output_en  = 1'b0;
        mem_data_out   = '0;
        case (state)
            WRITE: begin
                mem_enable   = 1'b1;
                mem_data_out = wdata_q;
            end
            RD_ISSUE, RD_CAPTURE: begin
                mem_enable     = 1'b1;
                mem_read_write = 1'b1;
                mem_output_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            count_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                count_q <= req_len;
            end
            if (state == RD_CAPTURE) begin
                rsp_rdata <= mem_data_in;
                rsp_valid <= 1'b1;
                rsp_last  <= (count_q == '0);
            end
            // A non-final handshake advances to the next beat of the burst.
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                if (!rsp_last) begin
                    addr_q  <= next_addr(addr_q);
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural word memory and a queue-based reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_last;
    logic        busy;
    logic [15:0] mem_address;
    logic        mem_read_write;
    logic        mem_enable;
    logic        mem_output_en;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .busy(busy), .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_enable(mem_enable), .mem_output_en(mem_output_en),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    // Word memory with a registered read path.
    logic [15:0] mem_arr [0:65535];
    logic [15:0] mem_oreg;
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_read_write) mem_oreg <= mem_arr[mem_address];
            else                mem_arr[mem_address] <= mem_data_out;
        end
    end
    assign mem_data_in = mem_output_en ? mem_oreg : 16'h0000;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic [15:0] ref_mem [int];
    beat_t       exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    bit          rand_rdy = 1'b0;
    bit          rdy_force = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sole driver of rsp_ready; changes only just after a rising edge.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: checks read addressing, RESP idling of the memory, and popped beats.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mem_enable && mem_read_write) begin
                    if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
                    else chk("rd_addr", mem_address, exp_q[0].addr);
                end
                if (rsp_valid) chk("mem_idle_in_resp", mem_enable, 0);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, b.data);
                        chk("rsp_last", rsp_last, b.last);
                        pops++;
                    end
                end
            end
        end
    end

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] len, input bit chk_lat);
        int n;
        beat_t b;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_len = len;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 200, 1);
        if (n >= 200) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (w) begin
            ref_mem[int'(a)] = d;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                b.addr = 16'(a + 16'(i));
                b.data = ref_rd(b.addr);
                b.last = (i == int'(len));
                exp_q.push_back(b);
            end
        end
        #1;
        req_valid = 1'b0;
        if (w) begin
            chk("wr_ready_low", req_ready, 0);
            chk("wr_enable", mem_enable, 1);
            chk("wr_rw", mem_read_write, 0);
            chk("wr_oe", mem_output_en, 0);
            chk("wr_addr", mem_address, a);
            chk("wr_data", mem_data_out, d);
            @(posedge clk);
            #1;
            chk("wr_ready_again", req_ready, 1);
        end else if (chk_lat) begin
            chk("lat_e0", rsp_valid, 0);
            @(posedge clk);
            #1;
            chk("lat_e1", rsp_valid, 0);
            @(posedge clk);
            #1;
            chk("lat_e2", rsp_valid, 1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 400, 1);
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_timeout", n < 50, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_last"}, rsp_last, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_rw"}, mem_read_write, 0);
        chk({tag, "_mem_enable"}, mem_enable, 0);
        chk({tag, "_mem_oe"}, mem_output_en, 0);
        chk({tag, "_mem_data_out"}, mem_data_out, 0);
    endtask

    initial begin
        int p;
        logic [15:0] snap;
        logic [15:0] a;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);
        chk("rel_mem_enable", mem_enable, 0);

        // Write then single read
        issue(1'b1, 16'h0010, 16'h1234, 2'd0, 1'b0);
        p = pops;
        issue(1'b0, 16'h0010, 16'h0000, 2'd0, 1'b1);
        wait_idle();
        chk("single_beats", 32'(pops - p), 1);

        // Four-beat burst
        for (int i = 0; i < 4; i++) issue(1'b1, 16'h0020 + 16'(i), 16'hA0A0 + 16'(i) * 16'h0101, 2'd0, 1'b0);
        p = pops;
        issue(1'b0, 16'h0020, 16'h0000, 2'd3, 1'b1);
        wait_idle();
        chk("burst_beats", 32'(pops - p), 4);

        // Backpressure on beat 1
        rdy_force = 1'b0;
        p = pops;
        issue(1'b0, 16'h0020, 16'h0000, 2'd3, 1'b0);
        wait_rsp_valid();
        snap = rsp_rdata;
        chk("bp_first_data", snap, 16'hA0A0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_data_held", rsp_rdata, snap);
            chk("bp_mem_idle", mem_enable, 0);
            chk("bp_last_low", rsp_last, 0);
        end
        rdy_force = 1'b1;
        wait_idle();
        chk("bp_beats", 32'(pops - p), 4);

        // Address wrap
        issue(1'b1, 16'hFFFF, 16'h5A5A, 2'd0, 1'b0);
        issue(1'b1, 16'h0000, 16'hC3C3, 2'd0, 1'b0);
        p = pops;
        issue(1'b0, 16'hFFFF, 16'h0000, 2'd1, 1'b1);
        wait_idle();
        chk("wrap_beats", 32'(pops - p), 2);

        // Reset while beat 2 of a burst is waiting
        p = pops;
        issue(1'b0, 16'h0020, 16'h0000, 2'd3, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (pops == p && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("mid_beat1_timeout", n < 50, 1);
        end
        rdy_force = 1'b0;
        @(posedge clk);
        wait_rsp_valid();
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rsp_valid_drop", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        chk_reset_outputs("mid");
        @(posedge clk);
        #1 reset = 1'b1;
        rdy_force = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_enable", mem_enable, 0);
        p = pops;
        issue(1'b0, 16'h0010, 16'h0000, 2'd0, 1'b1);
        wait_idle();
        chk("mid_after_beats", 32'(pops - p), 1);

        // Randomised traffic over a pre-written address pool, random backpressure
        for (int i = 0; i < 8; i++) issue(1'b1, 16'hFFFC + 16'(i), 16'($urandom), 2'd0, 1'b0);
        for (int i = 0; i < 11; i++) issue(1'b1, 16'h0030 + 16'(i), 16'($urandom), 2'd0, 1'b0);
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                            : 16'h0030 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) issue(1'b1, a, 16'($urandom), 2'd0, 1'b0);
            else                           issue(1'b0, a, 16'h0000, 2'($urandom_range(0, 3)), 1'b0);
        end
        rand_rdy = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller that sits directly upstream of the 16-bit word memory and is the only block that drives the memory's address, data, and control pins. It accepts single-word write requests and 1–4 beat incrementing read bursts from the CPU over a valid/ready request channel. It sequences the memory's registered read path (address issue, then data capture) and returns read data on a valid/ready response channel with backpressure.

## Interface
- address_size, 16, width of memory address
- data_size, 16, width of a memory word
- burst_bits, 2, width of req_len; maximum burst is 2**burst_bits beats
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  address_size  start address
- req_wdata  in  data_size  write data (writes only)
- req_len  in  burst_bits  read beats minus 1; ignored for writes
- rsp_valid  out  1  read beat available
- rsp_ready  in  1  consumer accepts beat
- rsp_rdata  out  data_size  read beat data
- rsp_last  out  1  final beat of the burst
- busy  out  1  state != IDLE
- mem_address  out  address_size  to memory address
- mem_read_write  out  1  to memory read_write (1 = read)
- mem_enable  out  1  to memory enable
- mem_output_en  out  1  to memory output_en
- mem_data_out  out  data_size  to memory data_in
- mem_data_in  in  data_size  from memory data_out

## Operation
- FSM states: IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RESP.
- IDLE: req_ready = 1 (gated by reset high). On req_valid, latch addr, wdata, len, and write into registers. Go to WRITE if req_write is 1, otherwise go to RD_ISSUE.
- WRITE: mem_enable=1, mem_read_write=0, mem_output_en=0, mem_address=addr reg, mem_data_out=wdata reg. The memory stores the word at the closing edge. Next state is IDLE. Writes produce no response.
- RD_ISSUE: mem_enable=1, mem_read_write=1, mem_output_en=1, mem_address=addr reg. The memory latches its output register at the closing edge. Next state is RD_CAPTURE.
- RD_CAPTURE: memory controls are held as in RD_ISSUE, so memory output is driven. At the closing edge: rsp_rdata <= mem_data_in, rsp_valid <= 1, rsp_last <= (beat count == 0). Next state is RESP.
- RESP: mem_enable=0. rsp_valid and rsp_rdata are held until rsp_ready.
  - On handshake with rsp_last=1: rsp_valid <= 0, go to IDLE.
  - Otherwise: rsp_valid <= 0, addr <= addr+1 mod 2**address_size, count <= count−1, go to RD_ISSUE.
- Outside the active states above: mem_enable, mem_read_write, mem_output_en, and mem_data_out are 0, and mem_address = addr reg.
- req_valid is ignored outside IDLE. The request is not consumed until req_ready is 1.
- Address arithmetic is unsigned and wraps, so 16'hFFFF+1 = 16'h0000. The beat count is a burst_bits-wide down-counter.
- rsp_rdata retains its last captured value until the next capture.

## Timing
- Reset (async, low) sets state=IDLE, and clears addr, wdata, count, rsp_valid, rsp_last, and rsp_rdata to 0. While reset is low, all mem_* outputs are 0 and req_ready=0. req_ready=1 in the first cycle after release.
- Reset mid-operation abandons the transaction immediately: rsp_valid drops asynchronously and no partial write is issued after the reset edge.
- Write: accepted at edge E. The WRITE cycle follows, the memory is updated at E+1, and req_ready is high again after E+1 (2 cycles per write).
- Read: accepted at edge E. RD_ISSUE runs E→E+1, capture happens at E+2, and rsp_valid is high after E+2.
- With rsp_ready held high, each beat takes 3 cycles, and the next beat's RD_ISSUE begins the cycle after the handshake.
- The earliest new request is accepted in the cycle after the final handshake.

## Test plan
- Reset: assert reset low mid-simulation → all outputs 0, busy=0. After release, req_ready=1 and mem_enable=0.
- Write then read: write 16'h1234 to 16'h0010, then read len=0 at 16'h0010 → rsp_valid rises 2 edges after accept, rsp_rdata=16'h1234, rsp_last=1.
- Burst: preload 0x0020–0x0023 with 16'hA0A0..16'hA3A3, then read len=3 → four beats in order, rsp_last only on the 4th, mem_address stepping 0x20→0x23.
- Backpressure: hold rsp_ready=0 for 5 cycles on beat 1 → rsp_valid and rsp_rdata are stable, mem_enable=0, no extra beats, and the burst resumes correctly after release.
- Wrap: preload 0xFFFF=16'h5A5A and 0x0000=16'hC3C3, then read len=1 at 16'hFFFF → beats 16'h5A5A then 16'hC3C3.
- Reset mid-burst: assert reset after beat 1 of a len=3 read → rsp_valid drops immediately, state=IDLE, and a subsequent single read returns correct data.
